alu_op_issuer: RTL



---
 rtl/alu_issuer_pkg.sv | 23 ++
 rtl/alu_op_issuer_if.sv | 49 ++++
 rtl/alu_issuer_regfile.sv | 36 +++
 rtl/alu_op_issuer.sv | 134 +++++++++++++
 4 files changed

// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU operation issuer.
//   SEL_*   : select codes understood by the 16-bit combinational ALU
//   state_t : issuer FSM states
// Optional build macro used by the issuer files: ALU_ISSUER_FLAGS_EN.
package alu_issuer_pkg;

    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_PASS = 3'b000;
    localparam logic [SEL_W-1:0] SEL_ADD  = 3'b001;
    localparam logic [SEL_W-1:0] SEL_SUB  = 3'b010;
    localparam logic [SEL_W-1:0] SEL_NOT  = 3'b011;
    localparam logic [SEL_W-1:0] SEL_CLR  = 3'b100;
    localparam logic [SEL_W-1:0] SEL_OR   = 3'b101;
    localparam logic [SEL_W-1:0] SEL_AND  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_op_issuer_if.sv
// Command/response bundle between a command source and the ALU issuer.
//   cmd_* : valid/ready command channel (master drives, slave accepts)
//   res_* : valid/ready result channel (slave drives, master consumes)
// With ALU_ISSUER_FLAGS_EN defined, res_zero/res_neg travel with res_data.
interface alu_op_issuer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned REG_AW = 2
);
    import alu_issuer_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [SEL_W-1:0]  cmd_op;
    logic              cmd_ld;
    logic [DATA_W-1:0] cmd_imm;
    logic [REG_AW-1:0] cmd_dst;
    logic [REG_AW-1:0] cmd_srca;
    logic [REG_AW-1:0] cmd_srcb;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [REG_AW-1:0] res_dst;
`ifdef ALU_ISSUER_FLAGS_EN
    logic              res_zero;
    logic              res_neg;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_ld, cmd_imm, cmd_dst, cmd_srca, cmd_srcb,
        input  cmd_ready,
        input  res_valid, res_data, res_dst,
`ifdef ALU_ISSUER_FLAGS_EN
        input  res_zero, res_neg,
`endif
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ld, cmd_imm, cmd_dst, cmd_srca, cmd_srcb,
        output cmd_ready,
        output res_valid, res_data, res_dst,
`ifdef ALU_ISSUER_FLAGS_EN
        output res_zero, res_neg,
`endif
        input  res_ready
    );

endinterface

// File: rtl/alu_issuer_regfile.sv
// Operand register file: NREG x DATA_W, two async read ports,
// one synchronous write port, synchronous clear on rst (clear wins over write).
//   rd_a_addr/rd_a_data, rd_b_addr/rd_b_data : read ports
//   wr_en/wr_addr/wr_data                    : write port
module alu_issuer_regfile #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 4,
    localparam int unsigned REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_a_addr,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [REG_AW-1:0] rd_b_addr,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_a_data = mem[rd_a_addr];
    assign rd_b_data = mem[rd_b_addr];

endmodule

// File: rtl/alu_op_issuer.sv
// Command front-end for the combinational ALU: accepts reg-to-reg or
// load-immediate commands, drives the ALU for one ISSUE cycle, writes the
// result back and returns it on the response channel.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : cmd_* command channel, res_* response channel
//   alu_a/alu_b/alu_sel : registered ALU drive, zero outside ISSUE
//   alu_out           : ALU combinational result
// Macro ALU_ISSUER_FLAGS_EN adds res_zero/res_neg captured with res_data.
module alu_op_issuer
    import alu_issuer_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREG   = 4,
    localparam int unsigned REG_AW = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_issuer_if.slave    bus,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out
);

    state_t            state, state_nxt;
    logic [REG_AW-1:0] dst_q, dst_nxt;
    logic [DATA_W-1:0] alu_a_nxt, alu_b_nxt;
    logic [SEL_W-1:0]  alu_sel_nxt;
    logic [DATA_W-1:0] res_data_nxt;
    logic [REG_AW-1:0] res_dst_nxt;
    logic [DATA_W-1:0] rd_a_data, rd_b_data;
    logic              wr_en;
`ifdef ALU_ISSUER_FLAGS_EN
    logic              res_zero_nxt, res_neg_nxt;
`endif

    // Operands are read at accept time so the ALU inputs are registered
    // straight into the ISSUE cycle.
    alu_issuer_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_a_addr (bus.cmd_srca),
        .rd_a_data (rd_a_data),
        .rd_b_addr (bus.cmd_srcb),
        .rd_b_data (rd_b_data),
        .wr_en     (wr_en),
        .wr_addr   (dst_q),
        .wr_data   (alu_out)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        dst_nxt      = dst_q;
        alu_a_nxt    = '0;
        alu_b_nxt    = '0;
        alu_sel_nxt  = SEL_PASS;
        res_data_nxt = bus.res_data;
        res_dst_nxt  = bus.res_dst;
        wr_en        = 1'b0;
`ifdef ALU_ISSUER_FLAGS_EN
        res_zero_nxt = bus.res_zero;
        res_neg_nxt  = bus.res_neg;
`endif
        case (state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = ST_ISSUE;
                    dst_nxt   = bus.cmd_dst;
                    if (bus.cmd_ld) begin
                        alu_a_nxt = bus.cmd_imm;
                    end else begin
                        alu_a_nxt   = rd_a_data;
                        alu_b_nxt   = rd_b_data;
                        alu_sel_nxt = bus.cmd_op;
                    end
                end
            end
            ST_ISSUE: begin
                state_nxt    = ST_RESP;
                wr_en        = 1'b1;
                res_data_nxt = alu_out;
                res_dst_nxt  = dst_q;
`ifdef ALU_ISSUER_FLAGS_EN
                res_zero_nxt = (alu_out == '0);
                res_neg_nxt  = alu_out[DATA_W-1];
`endif
            end
            ST_RESP: begin
                if (bus.res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            dst_q         <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_sel       <= SEL_PASS;
            bus.cmd_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_dst   <= '0;
`ifdef ALU_ISSUER_FLAGS_EN
            bus.res_zero  <= 1'b0;
            bus.res_neg   <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            dst_q         <= dst_nxt;
            alu_a         <= alu_a_nxt;
            alu_b         <= alu_b_nxt;
            alu_sel       <= alu_sel_nxt;
            bus.cmd_ready <= (state_nxt == ST_IDLE);
            bus.res_valid <= (state_nxt == ST_RESP);
            bus.res_data  <= res_data_nxt;
            bus.res_dst   <= res_dst_nxt;
`ifdef ALU_ISSUER_FLAGS_EN
            bus.res_zero  <= res_zero_nxt;
            bus.res_neg   <= res_neg_nxt;
`endif
        end
    end

endmodule
